// File: rtl/traffic_control_unit_if.sv
// Control/status bundle between the traffic sequencer and its datapath.
// The sequencer takes the slave view; the datapath or bench takes the master view.
interface traffic_control_unit_if #(
  parameter int IW = 3,
  parameter int RW = 2,
  parameter int CW = 4
);
  logic          run;
  logic          emerg;
  logic [IW-1:0] index;
  logic [RW-1:0] road;
  logic          counter_zero;
  logic [CW-1:0] timing_data;
  logic          load_counter;
  logic          shift_reg;
  logic          inc_index;
  logic          clear_index;
  logic          inc_road;
  logic          clear;
  logic          busy;
  logic          cycle_done;

  modport master (
    output run, emerg, index, road, counter_zero,
    input  timing_data, load_counter, shift_reg, inc_index, clear_index,
           inc_road, clear, busy, cycle_done
  );

  modport slave (
    input  run, emerg, index, road, counter_zero,
    output timing_data, load_counter, shift_reg, inc_index, clear_index,
           inc_road, clear, busy, cycle_done
  );
endinterface

// File: rtl/traffic_control_unit.sv
// Sequencing FSM for the traffic-light datapath: loads per-phase delays, waits
// for the counter to expire, steps phase/road, and handles emergency all-red.
module traffic_control_unit #(
  parameter int ROADS     = 4,
  parameter int LIGHTS    = 5,
  parameter int COUNT_MAX = 15,
  parameter int T_RED     = 4,
  parameter int T_RA      = 2,
  parameter int T_GREEN   = 10,
  parameter int T_AMBER   = 3,
  parameter int T_ALLRED  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  traffic_control_unit_if.slave bus
);
  localparam int CW = $clog2(COUNT_MAX);
  localparam int IW = $clog2(6);
  localparam int RW = $clog2(ROADS);

  localparam logic [IW-1:0] LAST_IDX  = IW'(LIGHTS - 1);
  localparam logic [RW-1:0] LAST_ROAD = RW'(ROADS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    EMERG = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic          load_counter;
  logic          shift_reg;
  logic          inc_index;
  logic          clear_index;
  logic          inc_road;
  logic          clear;
  logic          cycle_done;
  logic [CW-1:0] timing_data;

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Per-phase delay table; any index outside the table falls back to the red hold.
  always_comb begin
    timing_data = CW'(T_RED);
    case (int'(bus.index))
      0:       timing_data = CW'(T_RED);
      1:       timing_data = CW'(T_RA);
      2:       timing_data = CW'(T_GREEN);
      3:       timing_data = CW'(T_AMBER);
      4:       timing_data = CW'(T_ALLRED);
      default: timing_data = CW'(T_RED);
    endcase
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    load_counter = 1'b0;
    shift_reg    = 1'b0;
    inc_index    = 1'b0;
    clear_index  = 1'b0;
    inc_road     = 1'b0;
    clear        = 1'b0;
    cycle_done   = 1'b0;

    if (bus.emerg) begin
      // Emergency wins over everything, including a pending counter expiry.
      clear   = 1'b1;
      state_d = EMERG;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.run) state_d = LOAD;
        end
        LOAD: begin
          load_counter = 1'b1;
          state_d      = WAIT;
        end
        WAIT: begin
          if (bus.counter_zero) begin
            if (bus.index < LAST_IDX) begin
              shift_reg = 1'b1;
              inc_index = 1'b1;
              state_d   = LOAD;
            end else if (bus.road < LAST_ROAD) begin
              // Road handover; run is only re-examined on road boundaries.
              shift_reg   = 1'b1;
              clear_index = 1'b1;
              inc_road    = 1'b1;
              state_d     = bus.run ? LOAD : IDLE;
            end else begin
              // Last road done: datapath clear rewinds index, road and light.
              clear      = 1'b1;
              cycle_done = 1'b1;
              state_d    = bus.run ? LOAD : IDLE;
            end
          end
        end
        EMERG: begin
          clear   = 1'b1;
          state_d = bus.run ? LOAD : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.timing_data  = timing_data;
  assign bus.load_counter = load_counter;
  assign bus.shift_reg    = shift_reg;
  assign bus.inc_index    = inc_index;
  assign bus.clear_index  = clear_index;
  assign bus.inc_road     = inc_road;
  assign bus.clear        = clear;
  assign bus.cycle_done   = cycle_done;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_traffic_control_unit.sv
// Directed bench for traffic_control_unit: a small datapath model closes the
// loop; a second instance runs with a zero-length green phase.
module tb_traffic_control_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic emerg = 1'b0;

  int n_checks = 0;
  int n_err = 0;
  int total_cycles = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int b_green_cnt = 0;
  int b_green_len = 0;
  int t_tab[5] = '{4, 2, 10, 3, 1};

  always #5 clk = ~clk;

  traffic_control_unit_if #(.IW(3), .RW(2), .CW(4)) ifa ();
  traffic_control_unit_if #(.IW(3), .RW(2), .CW(4)) ifb ();

  traffic_control_unit dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  traffic_control_unit #(.T_GREEN(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  // Datapath models: phase index, road, and down-counter driven by the strobes.
  logic [2:0] idx_a, idx_b;
  logic [1:0] rd_a, rd_b;
  logic [3:0] cnt_a, cnt_b;

  assign ifa.run = run;
  assign ifa.emerg = emerg;
  assign ifa.index = idx_a;
  assign ifa.road = rd_a;
  assign ifa.counter_zero = (cnt_a == 4'd0);
  assign ifb.run = run;
  assign ifb.emerg = emerg;
  assign ifb.index = idx_b;
  assign ifb.road = rd_b;
  assign ifb.counter_zero = (cnt_b == 4'd0);

  always @(posedge clk) begin
    if (reset || ifa.clear) begin
      idx_a <= 3'd0; rd_a <= 2'd0; cnt_a <= 4'hF;
    end else begin
      if (ifa.load_counter) cnt_a <= ifa.timing_data;
      else if (cnt_a != 4'd0) cnt_a <= cnt_a - 4'd1;
      if (ifa.inc_index) idx_a <= idx_a + 3'd1;
      else if (ifa.clear_index) idx_a <= 3'd0;
      if (ifa.inc_road) rd_a <= rd_a + 2'd1;
    end
  end

  always @(posedge clk) begin
    if (reset || ifb.clear) begin
      idx_b <= 3'd0; rd_b <= 2'd0; cnt_b <= 4'hF;
    end else begin
      if (ifb.load_counter) cnt_b <= ifb.timing_data;
      else if (cnt_b != 4'd0) cnt_b <= cnt_b - 4'd1;
      if (ifb.inc_index) idx_b <= idx_b + 3'd1;
      else if (ifb.clear_index) idx_b <= 3'd0;
      if (ifb.inc_road) rd_b <= rd_b + 2'd1;
    end
  end

  // Mid-cycle monitors: strobe exclusivity, cycle_done pulses, green length of instance B.
  always @(negedge clk) begin
    if (!reset) begin
      if ((ifa.inc_index && ifa.clear_index) || (ifa.inc_road && ifa.clear) ||
          (ifb.inc_index && ifb.clear_index) || (ifb.inc_road && ifb.clear))
        overlap_cnt++;
      if (ifa.cycle_done) done_cnt++;
    end
    if (reset || ifb.clear) begin
      b_green_cnt = 0;
    end else if (ifb.load_counter && idx_b == 3'd2) begin
      b_green_cnt = 1;
    end else if (b_green_cnt != 0) begin
      b_green_cnt++;
      if (ifb.shift_reg) begin
        b_green_len = b_green_cnt;
        b_green_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on a LOAD cycle; runs one phase through its exit cycle, then steps once more.
  task automatic run_phase(input int r, input int p);
    int len;
    bit exited;
    logic [5:0] ev;
    len = 1;
    exited = 1'b0;
    ev = '0;
    check($sformatf("r%0dp%0d_load", r, p), {31'd0, ifa.load_counter}, 1);
    check($sformatf("r%0dp%0d_clear_at_load", r, p), {31'd0, ifa.clear}, 0);
    check($sformatf("r%0dp%0d_index", r, p), {29'd0, ifa.index}, p);
    check($sformatf("r%0dp%0d_road", r, p), {30'd0, ifa.road}, r);
    check($sformatf("r%0dp%0d_timing", r, p), {28'd0, ifa.timing_data}, t_tab[p]);
    for (int i = 0; i < 40; i++) begin
      step();
      len++;
      if (ifa.shift_reg || ifa.clear) begin
        exited = 1'b1;
        ev = {ifa.shift_reg, ifa.inc_index, ifa.clear_index, ifa.inc_road,
              ifa.clear, ifa.cycle_done};
        break;
      end
    end
    check($sformatf("r%0dp%0d_exit_seen", r, p), {31'd0, exited}, 1);
    check($sformatf("r%0dp%0d_len", r, p), len, t_tab[p] + 2);
    if (p < 4)      check($sformatf("r%0dp%0d_strobes", r, p), {26'd0, ev}, 6'b110000);
    else if (r < 3) check($sformatf("r%0dp%0d_strobes", r, p), {26'd0, ev}, 6'b101100);
    else            check($sformatf("r%0dp%0d_strobes", r, p), {26'd0, ev}, 6'b000011);
    total_cycles += len;
    step();
  endtask

  int extra;

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_strobes", {24'd0, ifa.load_counter, ifa.shift_reg, ifa.inc_index,
          ifa.clear_index, ifa.inc_road, ifa.clear, ifa.busy, ifa.cycle_done}, 0);
    check("rst_timing", {28'd0, ifa.timing_data}, 4);

    // Release with run high: IDLE this cycle, LOAD on the next
    reset = 1'b0;
    run = 1'b1;
    #1;
    check("idle_no_load", {31'd0, ifa.load_counter}, 0);
    step();
    check("busy_after_start", {31'd0, ifa.busy}, 1);

    // First full rotation: 4 roads x 30 cycles, one cycle_done
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 5; p++)
        run_phase(r, p);
    check("rotation_cycles", total_cycles, 120);
    check("cycle_done_count", done_cnt, 1);

    // Second rotation up to the green of road 2, then a 3-cycle emergency
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 5; p++)
        run_phase(r, p);
    run_phase(2, 0);
    run_phase(2, 1);
    repeat (3) step();
    emerg = 1'b1;
    #1;
    check("emerg_detect_clear", {31'd0, ifa.clear}, 1);
    check("emerg_detect_others", {27'd0, ifa.load_counter, ifa.shift_reg, ifa.inc_index,
          ifa.clear_index, ifa.inc_road}, 0);
    step();
    check("emerg_c1_clear", {31'd0, ifa.clear}, 1);
    step();
    check("emerg_c2_clear", {31'd0, ifa.clear}, 1);
    step();
    emerg = 1'b0;
    #1;
    check("emerg_c3_clear", {31'd0, ifa.clear}, 1);
    step();
    run_phase(0, 0);

    // Drop run during road 1 green: road 1 completes, then IDLE
    for (int p = 1; p < 5; p++) run_phase(0, p);
    run_phase(1, 0);
    run_phase(1, 1);
    run = 1'b0;
    run_phase(1, 2);
    run_phase(1, 3);
    run_phase(1, 4);
    check("stop_busy", {31'd0, ifa.busy}, 0);
    check("stop_road", {30'd0, ifa.road}, 2);
    check("stop_index", {29'd0, ifa.index}, 0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifa.inc_road || ifa.load_counter || ifa.busy) extra++;
    end
    check("idle_quiet", extra, 0);

    // Emergency raised while IDLE
    emerg = 1'b1;
    #1;
    check("idle_emerg_clear", {31'd0, ifa.clear}, 1);
    check("idle_emerg_busy", {31'd0, ifa.busy}, 0);
    step();
    check("idle_emerg_state_busy", {31'd0, ifa.busy}, 1);
    emerg = 1'b0;
    #1;
    check("idle_emerg_exit_clear", {31'd0, ifa.clear}, 1);
    step();
    check("idle_emerg_back_idle", {30'd0, ifa.busy, ifa.clear}, 0);

    // Synchronous reset mid-operation
    run = 1'b1;
    step();
    check("restart_load", {31'd0, ifa.load_counter}, 1);
    repeat (2) step();
    reset = 1'b1;
    step();
    check("midrst_idle", {30'd0, ifa.busy, ifa.load_counter}, 0);
    reset = 1'b0;
    run = 1'b0;
    step();

    // Global properties
    check("strobe_exclusive", overlap_cnt, 0);
    check("zero_green_len", b_green_len, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
